// File: rtl/seq_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_run_ctrl
// Purpose  : Run controller that walks a state value from a first state to a
//            last state with a programmable dwell, step count, pause and abort.
// Revision : 1.0 - initial release
// ============================================================================
module seq_run_ctrl #(
    parameter int STATE_W = 3,
    parameter int CNT_W   = 8,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] cfg_first,
    input  logic [STATE_W-1:0] cfg_last,
    input  logic               cfg_dir,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [CNT_W-1:0]   cfg_steps,
    input  logic               pause,
    input  logic               abort,
    output logic [STATE_W-1:0] seq_state,
    output logic               seq_valid,
    output logic [CNT_W-1:0]   step_idx,
    output logic               busy,
    output logic               done,
    output logic               aborted
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } fsm_t;

    fsm_t               r_fsm,       w_fsm_nxt;
    logic [STATE_W-1:0] r_first,     w_first_nxt;
    logic [STATE_W-1:0] r_last,      w_last_nxt;
    logic               r_dir,       w_dir_nxt;
    logic [DWELL_W-1:0] r_dwell,     w_dwell_nxt;
    logic [CNT_W-1:0]   r_steps,     w_steps_nxt;
    logic [DWELL_W-1:0] r_dwell_cnt, w_dwell_cnt_nxt;
    logic [STATE_W-1:0] r_seq_state, w_seq_state_nxt;
    logic               r_seq_valid, w_seq_valid_nxt;
    logic [CNT_W-1:0]   r_step_idx,  w_step_idx_nxt;
    logic               r_busy,      w_busy_nxt;
    logic               r_done,      w_done_nxt;
    logic               r_aborted,   w_aborted_nxt;

    logic               w_expire;
    logic               w_last_step;
    logic [STATE_W-1:0] w_adv_state;

    assign w_expire    = (r_dwell_cnt == r_dwell);
    assign w_last_step = (r_steps != '0) && (r_step_idx == (r_steps - CNT_W'(1)));
    // Reaching the last state loops back to first; otherwise step with natural wrap.
    assign w_adv_state = (r_seq_state == r_last) ? r_first :
                         (r_dir ? (r_seq_state - STATE_W'(1)) : (r_seq_state + STATE_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= ST_IDLE;
            r_first     <= '0;
            r_last      <= '0;
            r_dir       <= 1'b0;
            r_dwell     <= '0;
            r_steps     <= '0;
            r_dwell_cnt <= '0;
            r_seq_state <= '0;
            r_seq_valid <= 1'b0;
            r_step_idx  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            r_first     <= w_first_nxt;
            r_last      <= w_last_nxt;
            r_dir       <= w_dir_nxt;
            r_dwell     <= w_dwell_nxt;
            r_steps     <= w_steps_nxt;
            r_dwell_cnt <= w_dwell_cnt_nxt;
            r_seq_state <= w_seq_state_nxt;
            r_seq_valid <= w_seq_valid_nxt;
            r_step_idx  <= w_step_idx_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_aborted   <= w_aborted_nxt;
        end
    end

    always_comb begin
        w_fsm_nxt       = r_fsm;
        w_first_nxt     = r_first;
        w_last_nxt      = r_last;
        w_dir_nxt       = r_dir;
        w_dwell_nxt     = r_dwell;
        w_steps_nxt     = r_steps;
        w_dwell_cnt_nxt = r_dwell_cnt;
        w_seq_state_nxt = r_seq_state;
        w_seq_valid_nxt = r_seq_valid;
        w_step_idx_nxt  = r_step_idx;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_aborted_nxt   = 1'b0;

        case (r_fsm)
            ST_IDLE: begin
                w_seq_valid_nxt = 1'b0;
                w_busy_nxt      = 1'b0;
                if (start && !abort) begin
                    w_fsm_nxt       = ST_RUN;
                    w_first_nxt     = cfg_first;
                    w_last_nxt      = cfg_last;
                    w_dir_nxt       = cfg_dir;
                    w_dwell_nxt     = cfg_dwell;
                    w_steps_nxt     = cfg_steps;
                    w_dwell_cnt_nxt = '0;
                    w_seq_state_nxt = cfg_first;
                    w_step_idx_nxt  = '0;
                    w_seq_valid_nxt = 1'b1;
                    w_busy_nxt      = 1'b1;
                end
            end
            ST_RUN: begin
                // Priority: abort, then pause, then dwell expiry.
                if (abort) begin
                    w_fsm_nxt       = ST_IDLE;
                    w_aborted_nxt   = 1'b1;
                    w_busy_nxt      = 1'b0;
                    w_seq_valid_nxt = 1'b0;
                end else if (pause) begin
                    w_fsm_nxt       = ST_PAUSED;
                    w_seq_valid_nxt = 1'b0;
                end else if (w_expire) begin
                    if (w_last_step) begin
                        w_fsm_nxt       = ST_IDLE;
                        w_done_nxt      = 1'b1;
                        w_busy_nxt      = 1'b0;
                        w_seq_valid_nxt = 1'b0;
                    end else begin
                        w_seq_state_nxt = w_adv_state;
                        w_step_idx_nxt  = r_step_idx + CNT_W'(1);
                        w_dwell_cnt_nxt = '0;
                    end
                end else begin
                    w_dwell_cnt_nxt = r_dwell_cnt + DWELL_W'(1);
                end
            end
            ST_PAUSED: begin
                if (abort) begin
                    w_fsm_nxt       = ST_IDLE;
                    w_aborted_nxt   = 1'b1;
                    w_busy_nxt      = 1'b0;
                    w_seq_valid_nxt = 1'b0;
                end else if (!pause) begin
                    w_fsm_nxt       = ST_RUN;
                    w_seq_valid_nxt = 1'b1;
                end
            end
            default: begin
                w_fsm_nxt       = ST_IDLE;
                w_seq_valid_nxt = 1'b0;
                w_busy_nxt      = 1'b0;
            end
        endcase
    end

    assign seq_state = r_seq_state;
    assign seq_valid = r_seq_valid;
    assign step_idx  = r_step_idx;
    assign busy      = r_busy;
    assign done      = r_done;
    assign aborted   = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_seq_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_run_ctrl
// Purpose  : Scoreboard bench for seq_run_ctrl with a run-time reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_run_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] cfg_first;
    logic [2:0] cfg_last;
    logic       cfg_dir;
    logic [3:0] cfg_dwell;
    logic [7:0] cfg_steps;
    logic       pause;
    logic       abort;
    logic [2:0] seq_state;
    logic       seq_valid;
    logic [7:0] step_idx;
    logic       busy;
    logic       done;
    logic       aborted;

    seq_run_ctrl #(.STATE_W(3), .CNT_W(8), .DWELL_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_first (cfg_first),
        .cfg_last  (cfg_last),
        .cfg_dir   (cfg_dir),
        .cfg_dwell (cfg_dwell),
        .cfg_steps (cfg_steps),
        .pause     (pause),
        .abort     (abort),
        .seq_state (seq_state),
        .seq_valid (seq_valid),
        .step_idx  (step_idx),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic       valid;
        logic [7:0] idx;
        logic       chk_idx;
        logic       busy;
        logic       done;
        logic       ab;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Model: a run is described by its latched config and the count of RUN
    // cycles that have elapsed (t); everything visible follows from those.
    int     m_mode = 0;     // 0 idle, 1 run, 2 paused
    longint m_t    = 0;
    int     m_f = 0, m_l = 0, m_dir = 0, m_dw = 0, m_steps = 0;
    int     m_last = 0;
    bit     m_idx_known = 1'b1;

    int p_first = 0, p_last = 0, p_dir = 0, p_dwell = 0, p_steps = 0;

    function automatic int state_at(longint k);
        int len;
        int off;
        len = ((m_dir != 0 ? (m_f - m_l) : (m_l - m_f)) & 7) + 1;
        off = int'(k % longint'(len));
        return (m_dir != 0) ? ((m_f - off) & 7) : ((m_f + off) & 7);
    endfunction

    task automatic tick(input bit r, input bit st, input bit ab, input bit pa, input bit scr);
        exp_t   e;
        longint k;
        @(negedge clk);
        if (scr) begin
            p_first = $urandom_range(0, 7);
            p_last  = $urandom_range(0, 7);
            p_dir   = $urandom_range(0, 1);
            p_dwell = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
            p_steps = ($urandom_range(0, 6) == 0) ? 0 : $urandom_range(1, 12);
        end
        rst = r; start = st; abort = ab; pause = pa;
        cfg_first = 3'(p_first); cfg_last = 3'(p_last); cfg_dir = 1'(p_dir);
        cfg_dwell = 4'(p_dwell); cfg_steps = 8'(p_steps);
        e.done = 1'b0;
        e.ab   = 1'b0;
        if (r) begin
            m_mode = 0; m_last = 0; m_idx_known = 1'b1;
        end else begin
            case (m_mode)
                0: if (st && !ab) begin
                    m_f = p_first; m_l = p_last; m_dir = p_dir;
                    m_dw = p_dwell; m_steps = p_steps;
                    m_t = 0; m_mode = 1;
                end
                1: if (ab) begin
                    m_last = state_at(m_t / (m_dw + 1));
                    m_mode = 0; e.ab = 1'b1; m_idx_known = 1'b0;
                end else if (pa) begin
                    m_mode = 2;
                end else begin
                    m_t++;
                    if (m_steps != 0 && (m_t / (m_dw + 1)) == longint'(m_steps)) begin
                        m_last = state_at(m_steps - 1);
                        m_mode = 0; e.done = 1'b1; m_idx_known = 1'b0;
                    end
                end
                default: if (ab) begin
                    m_last = state_at(m_t / (m_dw + 1));
                    m_mode = 0; e.ab = 1'b1; m_idx_known = 1'b0;
                end else if (!pa) begin
                    m_mode = 1;
                end
            endcase
        end
        k         = m_t / (m_dw + 1);
        e.valid   = (m_mode == 1);
        e.busy    = (m_mode != 0);
        e.st      = (m_mode == 0) ? 3'(m_last) : 3'(state_at(k));
        e.idx     = (m_mode == 0) ? 8'd0 : 8'(k % 256);
        e.chk_idx = (m_mode != 0) || m_idx_known;
        q.push_back(e);
    endtask

    task automatic run_start(input int f, input int l, input int d, input int dw, input int s);
        p_first = f; p_last = l; p_dir = d; p_dwell = dw; p_steps = s;
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every cycle the DUT presents its registered outputs.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (seq_state !== e.st || seq_valid !== e.valid || busy !== e.busy ||
                    done !== e.done || aborted !== e.ab ||
                    (e.chk_idx && step_idx !== e.idx)) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got st=%0d v=%0b idx=%0d busy=%0b done=%0b ab=%0b exp st=%0d v=%0b idx=%0d(chk %0b) busy=%0b done=%0b ab=%0b",
                             cyc, seq_state, seq_valid, step_idx, busy, done, aborted,
                             e.st, e.valid, e.idx, e.chk_idx, e.busy, e.done, e.ab);
                end
            end
        end
    end

    initial begin
        bit pa_lvl;
        rst = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0;
        cfg_first = '0; cfg_last = '0; cfg_dir = 1'b0; cfg_dwell = '0; cfg_steps = '0;

        // Reset held with start asserted
        p_first = 3; p_last = 4; p_steps = 2;
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Basic increment walk with loop-back
        run_start(2, 5, 0, 0, 6);
        idle(9);

        // Wrap through zero, both directions
        run_start(6, 1, 0, 2, 4);
        idle(15);
        run_start(1, 6, 1, 2, 4);
        idle(15);

        // Continuous mode past the step index wrap, then abort
        run_start(0, 3, 0, 0, 0);
        idle(300);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Pause coinciding with dwell expiry
        run_start(0, 7, 0, 3, 3);
        idle(3);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(14);

        // start with abort in IDLE, abort while paused, start during run
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        run_start(4, 4, 1, 1, 5);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(2);
        run_start(5, 2, 1, 1, 5);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Randomized traffic with config churn every cycle
        pa_lvl = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) pa_lvl = ~pa_lvl;
            tick($urandom_range(0, 499) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 39) == 0, pa_lvl, 1'b1);
        end
        idle(2);

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expectations, exp 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
